// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (count, big-endian words, XOR checksum),
// writes the words to sequential addresses from 0 and holds the CPU stalled for the whole session.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [15:0]       WR_DATA,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_FIN
    } state_t;

    state_t            state, state_nx;
    logic [7:0]        n_words;
    logic [7:0]        words;
    logic [7:0]        csum;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              err_q;
    logic              xfer;

    always_comb begin
        RX_READY = (state == S_COUNT) || (state == S_HI) ||
                   (state == S_LO)    || (state == S_CSUM);
        xfer     = RX_VALID && RX_READY;
        WR_EN    = (state == S_WRITE);
        BUSY     = (state != S_IDLE);
        CPU_HOLD = (state != S_IDLE);
        DONE     = (state == S_FIN);
        WR_ADDR  = wr_addr_q;
        WR_DATA  = wr_data_q;
        ERR      = err_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (START) state_nx = S_COUNT;
            S_COUNT: if (xfer)  state_nx = (RX_DATA == 8'd0) ? S_CSUM : S_HI;
            S_HI:    if (xfer)  state_nx = S_LO;
            S_LO:    if (xfer)  state_nx = S_WRITE;
            // words never exceeds 254 here, so the 8-bit increment cannot wrap
            S_WRITE: state_nx = ((words + 8'd1) == n_words) ? S_CSUM : S_HI;
            S_CSUM:  if (xfer)  state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            n_words   <= '0;
            words     <= '0;
            csum      <= '0;
            hi_byte   <= '0;
            addr      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        err_q <= 1'b0;
                        words <= '0;
                        addr  <= '0;
                        csum  <= '0;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        n_words <= RX_DATA;
                        csum    <= RX_DATA;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi_byte <= RX_DATA;
                        csum    <= csum ^ RX_DATA;
                    end
                end
                S_LO: begin
                    // Address/data are captured here so they persist after the write cycle
                    if (xfer) begin
                        wr_data_q <= {hi_byte, RX_DATA};
                        wr_addr_q <= addr;
                        csum      <= csum ^ RX_DATA;
                    end
                end
                S_WRITE: begin
                    addr  <= addr + 1'b1;
                    words <= words + 8'd1;
                end
                S_CSUM: begin
                    if (xfer) err_q <= (RX_DATA != csum);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: an 8-bit-address instance plus a 2-bit-address instance
// sharing stimulus, used to observe address wrap.
module tb_imem_loader;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        WR_EN;
    logic [7:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    logic        s_rx_ready, s_wr_en, s_cpu_hold, s_busy, s_done, s_err;
    logic [1:0]  s_wr_addr;
    logic [15:0] s_wr_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [7:0]  waddr_q[$];
    logic [15:0] wdata_q[$];
    int          wcyc_q[$];
    logic [1:0]  saddr_q[$];
    logic [15:0] sdata_q[$];

    imem_loader #(.ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    imem_loader #(.ADDR_W(2)) dut_small (
        .CLK(CLK), .RST(RST), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(s_rx_ready), .WR_EN(s_wr_en), .WR_ADDR(s_wr_addr), .WR_DATA(s_wr_data),
        .CPU_HOLD(s_cpu_hold), .BUSY(s_busy), .DONE(s_done), .ERR(s_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WR_EN) begin
            waddr_q.push_back(WR_ADDR);
            wdata_q.push_back(WR_DATA);
            wcyc_q.push_back(cyc);
        end
        if (s_wr_en) begin
            saddr_q.push_back(s_wr_addr);
            sdata_q.push_back(s_wr_data);
        end
        if (DONE) done_cnt = done_cnt + 1;
    end

    task automatic clear_logs();
        waddr_q.delete();
        wdata_q.delete();
        wcyc_q.delete();
        saddr_q.delete();
        sdata_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    // Offers one byte after `gap` idle cycles (junk on RX_DATA during the gap); returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            RX_VALID = 1'b0;
            RX_DATA  = 8'($urandom);
            @(posedge CLK); #1;
        end
        RX_VALID = 1'b1;
        RX_DATA  = b;
        t = 0;
        while (!RX_READY && t < 20) begin
            @(posedge CLK); #1;
            t++;
        end
        if (!RX_READY) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: RX_READY=%b after %0d cycles, required 1", RX_READY, t);
        end else begin
            @(posedge CLK); #1;
        end
        RX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (RX_READY !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", RX_READY); end
        checks++; if (WR_EN !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", WR_EN); end
        checks++; if (WR_ADDR !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", WR_ADDR); end
        checks++; if (WR_DATA !== 16'h0000) begin errors++; $display("FAIL reset_wr_data: got %h want 0000", WR_DATA); end
        checks++; if (CPU_HOLD !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold: got %b want 0", CPU_HOLD); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Frame 02 | 31 02 | 32 05 | csum; gaps > 0 randomises RX_VALID idle time up to max_gap cycles.
    task automatic run_two_word(input logic [7:0] csum_byte, input int max_gap, input string tag);
        logic [7:0] bytes[5];
        bytes = '{8'h02, 8'h31, 8'h02, 8'h32, 8'h05};
        clear_logs();
        do_start();
        checks++; if (BUSY !== 1'b1 || CPU_HOLD !== 1'b1 || RX_READY !== 1'b1) begin
            errors++; $display("FAIL %s_start: busy=%b hold=%b ready=%b want 1 1 1", tag, BUSY, CPU_HOLD, RX_READY);
        end
        foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        send_byte(csum_byte, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", tag, DONE); end
        checks++; if (ERR !== (csum_byte != 8'h06)) begin errors++; $display("FAIL %s_err: got %b want %b", tag, ERR, csum_byte != 8'h06); end
        @(posedge CLK); #1;
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0 || CPU_HOLD !== 1'b0) begin
            errors++; $display("FAIL %s_end: done=%b busy=%b hold=%b want 0 0 0", tag, DONE, BUSY, CPU_HOLD);
        end
        checks++; if (ERR !== (csum_byte != 8'h06)) begin errors++; $display("FAIL %s_err_sticky: got %b want %b", tag, ERR, csum_byte != 8'h06); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_cycles: got %0d want 1", tag, done_cnt); end
        checks++; if (waddr_q.size() !== 2) begin
            errors++; $display("FAIL %s_write_count: got %0d want 2", tag, waddr_q.size());
        end else begin
            checks++; if (waddr_q[0] !== 8'h00 || wdata_q[0] !== 16'h3102) begin errors++; $display("FAIL %s_write0: got %h/%h want 00/3102", tag, waddr_q[0], wdata_q[0]); end
            checks++; if (waddr_q[1] !== 8'h01 || wdata_q[1] !== 16'h3205) begin errors++; $display("FAIL %s_write1: got %h/%h want 01/3205", tag, waddr_q[1], wdata_q[1]); end
            if (max_gap == 0) begin
                checks++; if (wcyc_q[1] - wcyc_q[0] !== 3) begin errors++; $display("FAIL %s_write_spacing: got %0d want 3", tag, wcyc_q[1] - wcyc_q[0]); end
            end
        end
    endtask

    task automatic test_basic();
        run_two_word(8'h06, 0, "basic");
    endtask

    task automatic test_csum_err();
        run_two_word(8'h07, 0, "csum_err");
    endtask

    task automatic test_zero(input logic [7:0] csum_byte, input logic exp_err);
        clear_logs();
        do_start();
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL zero_err_cleared: got %b want 0", ERR); end
        send_byte(8'h00, 0);
        send_byte(csum_byte, 0);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", DONE); end
        checks++; if (ERR !== exp_err) begin errors++; $display("FAIL zero_err: got %b want %b", ERR, exp_err); end
        @(posedge CLK); #1;
        checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL zero_end: busy=%b done=%b want 0 0", BUSY, DONE); end
        checks++; if (waddr_q.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", waddr_q.size()); end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) run_two_word(8'h06, 5, "gaps");
    endtask

    task automatic test_wrap();
        clear_logs();
        do_start();
        send_byte(8'h05, 0);
        for (int w = 1; w <= 5; w++) begin
            send_byte(8'h00, 0);
            send_byte(8'(w), 0);
        end
        send_byte(8'h04, 0);
        checks++; if (DONE !== 1'b1 || ERR !== 1'b0 || s_done !== 1'b1 || s_err !== 1'b0) begin
            errors++; $display("FAIL wrap_status: done=%b err=%b sdone=%b serr=%b want 1 0 1 0", DONE, ERR, s_done, s_err);
        end
        @(posedge CLK); #1;
        checks++; if (saddr_q.size() !== 5) begin
            errors++; $display("FAIL wrap_count: got %0d want 5", saddr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (saddr_q[i] !== 2'(i % 4) || sdata_q[i] !== 16'(i + 1)) begin
                    errors++; $display("FAIL wrap_write%0d: got %h/%h want %h/%h", i, saddr_q[i], sdata_q[i], 2'(i % 4), 16'(i + 1));
                end
            end
        end
        checks++; if (waddr_q.size() !== 5 || waddr_q[waddr_q.size()-1] !== 8'h04) begin
            errors++; $display("FAIL wrap_wide_last: count=%0d want 5, last addr want 04", waddr_q.size());
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h31, 0);
        send_byte(8'h02, 0);
        checks++; if (WR_EN !== 1'b1) begin errors++; $display("FAIL midrst_first_write: got %b want 1", WR_EN); end
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++; if (RX_READY !== 1'b0 || WR_EN !== 1'b0 || BUSY !== 1'b0 || CPU_HOLD !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: ready=%b wr=%b busy=%b hold=%b done=%b err=%b want all 0", RX_READY, WR_EN, BUSY, CPU_HOLD, DONE, ERR);
        end
        checks++; if (WR_ADDR !== 8'h00 || WR_DATA !== 16'h0000) begin errors++; $display("FAIL midrst_wr_bus: got %h/%h want 00/0000", WR_ADDR, WR_DATA); end
        checks++; if (s_rx_ready !== 1'b0 || s_busy !== 1'b0 || s_cpu_hold !== 1'b0) begin
            errors++; $display("FAIL midrst_small: ready=%b busy=%b hold=%b want 0 0 0", s_rx_ready, s_busy, s_cpu_hold);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        clear_logs();
        do_start();
        send_byte(8'h01, 0);
        START = 1'b1; @(posedge CLK); #1; START = 1'b0;
        checks++; if (BUSY !== 1'b1 || RX_READY !== 1'b1) begin errors++; $display("FAIL midrst_start_ignored_hi: busy=%b ready=%b want 1 1", BUSY, RX_READY); end
        send_byte(8'hAB, 0);
        START = 1'b1; @(posedge CLK); #1; START = 1'b0;
        send_byte(8'hCD, 0);
        send_byte(8'h67, 0);
        checks++; if (DONE !== 1'b1 || ERR !== 1'b0) begin errors++; $display("FAIL midrst_status: done=%b err=%b want 1 0", DONE, ERR); end
        @(posedge CLK); #1;
        checks++; if (waddr_q.size() !== 1) begin
            errors++; $display("FAIL midrst_count: got %0d want 1", waddr_q.size());
        end else begin
            checks++; if (waddr_q[0] !== 8'h00 || wdata_q[0] !== 16'hABCD) begin errors++; $display("FAIL midrst_write: got %h/%h want 00/abcd", waddr_q[0], wdata_q[0]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_csum_err();
        test_zero(8'h00, 1'b0);
        test_zero(8'h01, 1'b1);
        test_gaps();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
